// File: rtl/gamepad_input_decoder_if.sv
// Signal bundle between the serial gamepad PMOD and the input decoder.
// master: pad/stimulus side driving the serial pins and observing results.
// slave:  decoder side receiving the serial pins and producing decoded events.
interface gamepad_input_decoder_if;
    logic       pmod_data;
    logic       pmod_clk;
    logic       pmod_latch;
    logic [9:0] input_data;
    logic [4:0] button_state;
    logic       frame_valid;
    logic       frame_error;
    logic       controller_present;

    modport master (
        output pmod_data,
        output pmod_clk,
        output pmod_latch,
        input  input_data,
        input  button_state,
        input  frame_valid,
        input  frame_error,
        input  controller_present
    );

    modport slave (
        input  pmod_data,
        input  pmod_clk,
        input  pmod_latch,
        output input_data,
        output button_state,
        output frame_valid,
        output frame_error,
        output controller_present
    );
endinterface

// File: rtl/gamepad_input_decoder.sv
// SNES-style serial gamepad decoder: synchronises the PMOD latch/clock/data
// lines, assembles 12-bit frames, and turns committed frames into one-cycle
// press/release pulses plus held-button state. Held state is force-released
// if no valid frame arrives within TIMEOUT_CYCLES.
module gamepad_input_decoder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned NUM_BITS       = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input logic                     clk,
    input logic                     reset,
    gamepad_input_decoder_if.slave  pad
);

    localparam int unsigned CW = $clog2(NUM_BITS + 2);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(NUM_BITS + 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    // Frame bit positions; the first shifted bit (B) lands in the MSB.
    localparam int unsigned B_IDX     = NUM_BITS - 1;
    localparam int unsigned UP_IDX    = NUM_BITS - 5;
    localparam int unsigned DOWN_IDX  = NUM_BITS - 6;
    localparam int unsigned LEFT_IDX  = NUM_BITS - 7;
    localparam int unsigned RIGHT_IDX = NUM_BITS - 8;
    localparam int unsigned A_IDX     = NUM_BITS - 9;

    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic                   clk_hist_q;
    logic                   latch_hist_q;
    logic                   clk_rise_q;
    logic                   latch_rise_q;
    logic                   data_smp_q;

    logic [NUM_BITS-1:0]    shift_q, shift_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]          timeout_q, timeout_d;
    logic [9:0]             input_data_q, input_data_d;
    logic [4:0]             button_state_q, button_state_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   frame_error_q, frame_error_d;
    logic                   present_q, present_d;

    logic [4:0]             new_state;
    logic                   all_ones;

    // Synchronise the async pins and register detected rising edges with
    // the data sample that belongs to them.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync_q  <= '0;
            clk_sync_q   <= '0;
            latch_sync_q <= '0;
            clk_hist_q   <= 1'b0;
            latch_hist_q <= 1'b0;
            clk_rise_q   <= 1'b0;
            latch_rise_q <= 1'b0;
            data_smp_q   <= 1'b0;
        end else begin
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0],  pad.pmod_data};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0],   pad.pmod_clk};
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pad.pmod_latch};
            clk_hist_q   <= clk_sync_q[SYNC_STAGES-1];
            latch_hist_q <= latch_sync_q[SYNC_STAGES-1];
            clk_rise_q   <= clk_sync_q[SYNC_STAGES-1] & ~clk_hist_q;
            latch_rise_q <= latch_sync_q[SYNC_STAGES-1] & ~latch_hist_q;
            data_smp_q   <= data_sync_q[SYNC_STAGES-1];
        end
    end

    // Shift/count, frame commit, event generation and timeout release.
    always_comb begin
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        timeout_d      = (timeout_q == TO_MAX) ? timeout_q : timeout_q + 1'b1;
        input_data_d   = '0;
        button_state_d = button_state_q;
        frame_valid_d  = 1'b0;
        frame_error_d  = 1'b0;
        present_d      = present_q;

        if (clk_rise_q && (bit_cnt_q != CNT_SAT)) begin
            shift_d   = {shift_q[NUM_BITS-2:0], data_smp_q};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        all_ones  = &shift_d;
        new_state = all_ones ? 5'b00000
                             : {shift_d[A_IDX] | shift_d[B_IDX], shift_d[RIGHT_IDX],
                                shift_d[LEFT_IDX], shift_d[DOWN_IDX], shift_d[UP_IDX]};

        if (timeout_q == TO_MAX) begin
            input_data_d[4:0] = button_state_q;
            button_state_d    = '0;
            present_d         = 1'b0;
        end

        // The commit is evaluated after the shift and overrides the timeout.
        if (latch_rise_q) begin
            if (bit_cnt_d == CNT_FULL) begin
                input_data_d   = {new_state & ~button_state_q, button_state_q & ~new_state};
                button_state_d = new_state;
                present_d      = ~all_ones;
                timeout_d      = '0;
                frame_valid_d  = 1'b1;
            end else begin
                frame_error_d  = 1'b1;
            end
            bit_cnt_d = '0;
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            timeout_q      <= '0;
            input_data_q   <= '0;
            button_state_q <= '0;
            frame_valid_q  <= 1'b0;
            frame_error_q  <= 1'b0;
            present_q      <= 1'b0;
        end else begin
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            timeout_q      <= timeout_d;
            input_data_q   <= input_data_d;
            button_state_q <= button_state_d;
            frame_valid_q  <= frame_valid_d;
            frame_error_q  <= frame_error_d;
            present_q      <= present_d;
        end
    end

    assign pad.input_data         = input_data_q;
    assign pad.button_state       = button_state_q;
    assign pad.frame_valid        = frame_valid_q;
    assign pad.frame_error        = frame_error_q;
    assign pad.controller_present = present_q;

endmodule

// File: tb/tb_gamepad_input_decoder.sv
// Directed bench for gamepad_input_decoder: a default-timeout instance for
// frame decoding and a short-timeout instance for the hold release.
module tb_gamepad_input_decoder;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    gamepad_input_decoder_if pad();
    gamepad_input_decoder_if pad_to();

    gamepad_input_decoder dut (
        .clk   (clk),
        .reset (reset),
        .pad   (pad)
    );

    gamepad_input_decoder #(
        .TIMEOUT_CYCLES (16)
    ) dut_to (
        .clk   (clk),
        .reset (reset),
        .pad   (pad_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic d, input logic c, input logic l);
        pad.pmod_data     = d;
        pad.pmod_clk      = c;
        pad.pmod_latch    = l;
        pad_to.pmod_data  = d;
        pad_to.pmod_clk   = c;
        pad_to.pmod_latch = l;
    endtask

    task automatic send_bits(input logic [11:0] frame, input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = (i < 12) ? frame[11 - i] : 1'b0;
            set_pins(b, 1'b0, 1'b0);
            repeat (3) tick();
            set_pins(b, 1'b1, 1'b0);
            repeat (3) tick();
        end
        set_pins(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    // Raise latch just after an edge; nothing may appear for three edges,
    // returns positioned just after the fourth edge where the pulse is due.
    task automatic latch_open(input string tag);
        set_pins(1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 3; j++) begin
            tick();
            check({tag, "_early_valid"}, 32'(pad.frame_valid), 32'd0);
            check({tag, "_early_error"}, 32'(pad.frame_error), 32'd0);
        end
        tick();
    endtask

    task automatic latch_close(input string tag);
        tick();
        check({tag, "_after_data"},  32'(pad.input_data),  32'd0);
        check({tag, "_after_valid"}, 32'(pad.frame_valid), 32'd0);
        check({tag, "_after_error"}, 32'(pad.frame_error), 32'd0);
        set_pins(1'b0, 1'b0, 1'b0);
        repeat (4) tick();
    endtask

    task automatic expect_out(input string tag, input logic [9:0] id, input logic [4:0] bs,
                              input logic fv, input logic fe, input logic pr);
        check({tag, "_input_data"},   32'(pad.input_data),         32'(id));
        check({tag, "_button_state"}, 32'(pad.button_state),       32'(bs));
        check({tag, "_frame_valid"},  32'(pad.frame_valid),        32'(fv));
        check({tag, "_frame_error"},  32'(pad.frame_error),        32'(fe));
        check({tag, "_present"},      32'(pad.controller_present), 32'(pr));
    endtask

    initial begin
        reset = 1'b1;
        set_pins(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        expect_out("reset", 10'h000, 5'h00, 1'b0, 1'b0, 1'b0);

        // Up only: press up
        send_bits(12'h080, 12);
        latch_open("up");
        expect_out("up", 10'b00001_00000, 5'b00001, 1'b1, 1'b0, 1'b1);
        latch_close("up");

        // A + Right: press attack/right, release up
        send_bits(12'h018, 12);
        latch_open("aright");
        expect_out("aright", 10'b11000_00001, 5'b11000, 1'b1, 1'b0, 1'b1);
        latch_close("aright");

        // Same frame again: valid but no events
        send_bits(12'h018, 12);
        latch_open("repeat");
        expect_out("repeat", 10'h000, 5'b11000, 1'b1, 1'b0, 1'b1);
        latch_close("repeat");

        // Short frame of 11 bits
        send_bits(12'h000, 11);
        latch_open("short");
        expect_out("short", 10'h000, 5'b11000, 1'b0, 1'b1, 1'b1);
        latch_close("short");

        // Long frame of 14 bits
        send_bits(12'h000, 14);
        latch_open("long");
        expect_out("long", 10'h000, 5'b11000, 1'b0, 1'b1, 1'b1);
        latch_close("long");

        // All ones: controller absent, everything released
        send_bits(12'hFFF, 12);
        latch_open("absent");
        expect_out("absent", 10'b00000_11000, 5'b00000, 1'b1, 1'b0, 1'b0);
        latch_close("absent");

        // Reset in the middle of a frame
        send_bits(12'h080, 6);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        expect_out("midreset", 10'h000, 5'h00, 1'b0, 1'b0, 1'b0);

        // Fresh Left frame after the reset
        send_bits(12'h020, 12);
        latch_open("left");
        expect_out("left", 10'b00100_00000, 5'b00100, 1'b1, 1'b0, 1'b1);
        check("to_left_state", 32'(pad_to.button_state), 32'h04);
        check("to_left_data",  32'(pad_to.input_data),   32'h080);

        // Short-timeout instance releases Left 16 cycles after the commit
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("to_quiet_data", 32'(pad_to.input_data), 32'd0);
        end
        tick();
        check("to_release_data",    32'(pad_to.input_data),         32'h004);
        check("to_release_state",   32'(pad_to.button_state),       32'h00);
        check("to_release_present", 32'(pad_to.controller_present), 32'd0);
        check("main_still_held",    32'(pad.button_state),          32'h04);
        check("main_still_present", 32'(pad.controller_present),    32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("to_no_more_data", 32'(pad_to.input_data), 32'd0);
        end
        set_pins(1'b0, 1'b0, 1'b0);
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
